// File: rtl/report_wr_ctrl_pkg.sv
// Shared types and constants for the report ring writer.
package report_wr_ctrl_pkg;

  localparam int unsigned REPORT_W = 64;
  localparam logic [1:0] BRESP_OKAY = 2'b00;

  typedef enum logic [2:0] {
    StIdle,
    StWrLo,
    StBLo,
    StWrHi,
    StBHi,
    StAdv
  } state_e;

endpackage

// File: rtl/axil_wr_chan.sv
// Issues one AXI4-Lite AW+W pair and tracks the two handshakes independently.
module axil_wr_chan #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data,
  output logic [ADDR_W-1:0] awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [31:0]       wdata,
  output logic [3:0]        wstrb,
  output logic              wvalid,
  input  logic              wready,
  output logic              done
);

  logic aw_done_q, w_done_q;
  logic aw_hs, w_hs;

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  // Both channels complete, counting a handshake landing this very cycle.
  assign done  = (aw_done_q | aw_hs) & (w_done_q | w_hs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      awaddr    <= '0;
      wdata     <= '0;
      wstrb     <= 4'h0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else if (start) begin
      awvalid   <= 1'b1;
      wvalid    <= 1'b1;
      awaddr    <= addr;
      wdata     <= data;
      wstrb     <= 4'hF;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      if (aw_hs) begin
        awvalid   <= 1'b0;
        aw_done_q <= 1'b1;
      end
      if (w_hs) begin
        wvalid   <= 1'b0;
        w_done_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/report_wr_ctrl.sv
// Captures rising-edge HID reports and writes each as two 32-bit words into a memory ring.
module report_wr_ctrl
  import report_wr_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned PTR_W  = 8
) (
  input  logic                axi_clk,
  input  logic                rst,
  input  logic [REPORT_W-1:0] report_i,
  input  logic                report_valid_i,
  input  logic                enable_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic [PTR_W-1:0]    depth_i,
  output logic [ADDR_W-1:0]   awaddr_o,
  output logic                awvalid_o,
  input  logic                awready_i,
  output logic [31:0]         wdata_o,
  output logic [3:0]          wstrb_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  input  logic [1:0]          bresp_i,
  input  logic                bvalid_i,
  output logic                bready_o,
  output logic [PTR_W-1:0]    wr_ptr_o,
  output logic                irq_o,
  output logic                overflow_o,
  output logic                err_o
);

  state_e state_q, state_d;

  logic                valid_q;
  logic                hold_full_q;
  logic [REPORT_W-1:0] hold_q;
  logic [PTR_W-1:0]    wr_ptr_q;
  logic                overflow_q, err_q;

  logic             rpt_edge, hold_free, capture, drop;
  logic             start, sel_hi, chan_done, in_b;
  logic [ADDR_W-1:0] chan_addr;
  logic [31:0]      chan_data;
  logic [PTR_W-1:0] depth_eff;

  assign rpt_edge  = report_valid_i & ~valid_q;
  // The ADV cycle frees the hold, so a report arriving then is accepted.
  assign hold_free = ~hold_full_q | (state_q == StAdv);
  assign capture   = rpt_edge & enable_i & hold_free;
  assign drop      = rpt_edge & enable_i & ~hold_free;
  assign in_b      = (state_q == StBLo) | (state_q == StBHi);
  assign depth_eff = (depth_i == '0) ? PTR_W'(1) : depth_i;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    sel_hi  = 1'b0;
    unique case (state_q)
      StIdle: if (hold_full_q) begin
        state_d = StWrLo;
        start   = 1'b1;
      end
      StWrLo: if (chan_done) state_d = StBLo;
      StBLo: if (bvalid_i) begin
        state_d = StWrHi;
        start   = 1'b1;
        sel_hi  = 1'b1;
      end
      StWrHi: if (chan_done) state_d = StBHi;
      StBHi:  if (bvalid_i) state_d = StAdv;
      StAdv:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign chan_addr = base_addr_i + ADDR_W'({wr_ptr_q, 3'b000}) + (sel_hi ? ADDR_W'(4) : '0);
  assign chan_data = sel_hi ? hold_q[63:32] : hold_q[31:0];

  always_ff @(posedge axi_clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      valid_q     <= 1'b0;
      hold_full_q <= 1'b0;
      hold_q      <= '0;
      wr_ptr_q    <= '0;
      overflow_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= report_valid_i;
      if (capture) begin
        hold_q      <= report_i;
        hold_full_q <= 1'b1;
      end else if (state_q == StAdv) begin
        hold_full_q <= 1'b0;
      end
      if (drop) overflow_q <= 1'b1;
      if (in_b && bvalid_i && (bresp_i != BRESP_OKAY)) err_q <= 1'b1;
      if (state_q == StAdv) begin
        wr_ptr_q <= (wr_ptr_q == depth_eff - PTR_W'(1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
    end
  end

  axil_wr_chan #(
    .ADDR_W(ADDR_W)
  ) u_chan (
    .clk     (axi_clk),
    .rst     (rst),
    .start   (start),
    .addr    (chan_addr),
    .data    (chan_data),
    .awaddr  (awaddr_o),
    .awvalid (awvalid_o),
    .awready (awready_i),
    .wdata   (wdata_o),
    .wstrb   (wstrb_o),
    .wvalid  (wvalid_o),
    .wready  (wready_i),
    .done    (chan_done)
  );

  assign bready_o   = in_b;
  assign irq_o      = (state_q == StAdv);
  assign wr_ptr_o   = wr_ptr_q;
  assign overflow_o = overflow_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_report_wr_ctrl.sv
// Self-checking bench: AXI4-Lite slave model with a write scoreboard plus ring-pointer vectors.
module tb_report_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] report_i;
  logic        report_valid_i;
  logic        enable_i;
  logic [31:0] base_addr_i;
  logic [7:0]  depth_i;
  logic [31:0] awaddr_o;
  logic        awvalid_o;
  logic        awready_i;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        wvalid_o;
  logic        wready_i;
  logic [1:0]  bresp_i;
  logic        bvalid_i;
  logic        bready_o;
  logic [7:0]  wr_ptr_o;
  logic        irq_o;
  logic        overflow_o;
  logic        err_o;

  always #5 clk = ~clk;

  report_wr_ctrl #(
    .ADDR_W(32),
    .PTR_W (8)
  ) dut (
    .axi_clk        (clk),
    .rst            (rst),
    .report_i       (report_i),
    .report_valid_i (report_valid_i),
    .enable_i       (enable_i),
    .base_addr_i    (base_addr_i),
    .depth_i        (depth_i),
    .awaddr_o       (awaddr_o),
    .awvalid_o      (awvalid_o),
    .awready_i      (awready_i),
    .wdata_o        (wdata_o),
    .wstrb_o        (wstrb_o),
    .wvalid_o       (wvalid_o),
    .wready_i       (wready_i),
    .bresp_i        (bresp_i),
    .bvalid_i       (bvalid_i),
    .bready_o       (bready_o),
    .wr_ptr_o       (wr_ptr_o),
    .irq_o          (irq_o),
    .overflow_o     (overflow_o),
    .err_o          (err_o)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t sb_q[$];

  typedef struct {
    logic [63:0] rpt;
    logic [7:0]  depth;
    logic [31:0] exp_addr;
    logic [7:0]  exp_ptr;
  } vec_t;

  // Slave model knobs
  int   aw_delay = 0;
  int   w_delay  = 0;
  bit   b_hold   = 1'b0;
  bit   err_lo_once = 1'b0;
  int   wr_cnt   = 0;
  logic [7:0] m_ptr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] adv(input logic [7:0] p, input logic [7:0] d);
    logic [7:0] de;
    de = (d == 8'd0) ? 8'd1 : d;
    return (p == de - 8'd1) ? 8'd0 : p + 8'd1;
  endfunction

  task automatic push_rpt(input logic [31:0] addr, input logic [63:0] rpt);
    wr_t e;
    e.addr = addr;
    e.data = rpt[31:0];
    sb_q.push_back(e);
    e.addr = addr + 32'd4;
    e.data = rpt[63:32];
    sb_q.push_back(e);
  endtask

  // Expect a report at the modelled ring slot and advance the model pointer.
  task automatic expect_next(input logic [63:0] rpt);
    push_rpt(base_addr_i + {21'd0, m_ptr, 3'b000}, rpt);
    m_ptr = adv(m_ptr, depth_i);
  endtask

  task automatic send_report(input logic [63:0] rpt);
    @(negedge clk);
    report_i       = rpt;
    report_valid_i = 1'b1;
    @(negedge clk);
    report_valid_i = 1'b0;
  endtask

  task automatic wait_irq(input string name);
    int n = 0;
    while (!irq_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_irq"}, irq_o, 1'b1);
  endtask

  task automatic wait_bready(input string name);
    int n = 0;
    while (!bready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_bready"}, bready_o, 1'b1);
  endtask

  task automatic chk_all_reset(input string name);
    chk({name, "_awvalid"}, awvalid_o, 1'b0);
    chk({name, "_wvalid"}, wvalid_o, 1'b0);
    chk({name, "_bready"}, bready_o, 1'b0);
    chk({name, "_awaddr"}, awaddr_o, 32'd0);
    chk({name, "_wdata"}, wdata_o, 32'd0);
    chk({name, "_wstrb"}, wstrb_o, 4'h0);
    chk({name, "_irq"}, irq_o, 1'b0);
    chk({name, "_overflow"}, overflow_o, 1'b0);
    chk({name, "_err"}, err_o, 1'b0);
    chk({name, "_ptr"}, wr_ptr_o, 8'd0);
  endtask

  // AXI4-Lite slave: decides ready/valid at negedge, handshakes land on the next posedge.
  initial begin : slave
    int aw_cnt, w_cnt, b_state;
    bit got_aw, got_w, aw_hs_prev, w_hs_prev;
    logic [31:0] first_aw, first_w, cap_aw, cap_w;
    logic [1:0]  b_resp_next;
    wr_t e;
    awready_i = 1'b0;
    wready_i  = 1'b0;
    bvalid_i  = 1'b0;
    bresp_i   = 2'b00;
    aw_cnt = 0; w_cnt = 0; b_state = 0;
    got_aw = 0; got_w = 0; aw_hs_prev = 0; w_hs_prev = 0;
    first_aw = '0; first_w = '0; cap_aw = '0; cap_w = '0;
    b_resp_next = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0; bresp_i = 2'b00;
        aw_cnt = 0; w_cnt = 0; b_state = 0;
        got_aw = 0; got_w = 0; aw_hs_prev = 0; w_hs_prev = 0;
        continue;
      end
      if (aw_hs_prev) chk("aw_drop", awvalid_o, 1'b0);
      if (w_hs_prev) chk("w_drop", wvalid_o, 1'b0);
      aw_hs_prev = 0;
      w_hs_prev  = 0;
      if (b_state == 2) begin
        b_state = 0; got_aw = 0; got_w = 0; aw_cnt = 0; w_cnt = 0;
      end
      bvalid_i = 1'b0;
      if (b_state == 1 && !b_hold) begin
        bvalid_i = 1'b1;
        bresp_i  = b_resp_next;
        if (bready_o) b_state = 2;
      end
      awready_i = 1'b0;
      if (b_state == 0 && awvalid_o && !got_aw) begin
        if (aw_cnt == 0) first_aw = awaddr_o;
        if (aw_cnt >= aw_delay) begin
          awready_i = 1'b1; got_aw = 1; aw_hs_prev = 1; cap_aw = awaddr_o;
          chk("aw_stable", awaddr_o, first_aw);
        end
        aw_cnt++;
      end
      wready_i = 1'b0;
      if (b_state == 0 && wvalid_o && !got_w) begin
        if (w_cnt == 0) first_w = wdata_o;
        if (w_cnt >= w_delay) begin
          wready_i = 1'b1; got_w = 1; w_hs_prev = 1; cap_w = wdata_o;
          chk("w_stable", wdata_o, first_w);
          chk("wstrb", wstrb_o, 4'hF);
        end
        w_cnt++;
      end
      if (b_state == 0 && got_aw && got_w) begin
        wr_cnt++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_extra: got write %h@%h expected none", cap_w, cap_aw);
        end else begin
          e = sb_q.pop_front();
          chk("wr_addr", cap_aw, e.addr);
          chk("wr_data", cap_w, e.data);
        end
        b_resp_next = 2'b00;
        if (err_lo_once && cap_aw[2] == 1'b0) begin
          b_resp_next = 2'b10;
          err_lo_once = 1'b0;
        end
        b_state = 1;
      end
    end
  end

  vec_t vecs[8];

  initial begin : main
    int wr_base;
    vecs[0] = '{64'h1122334455667788, 8'd3, 32'h1000, 8'd1};
    vecs[1] = '{64'hA5A5A5A5_0F0F0F0F, 8'd3, 32'h1008, 8'd2};
    vecs[2] = '{64'hDEADBEEF_CAFEF00D, 8'd3, 32'h1010, 8'd0};
    vecs[3] = '{64'h01234567_89ABCDEF, 8'd3, 32'h1000, 8'd1};
    vecs[4] = '{64'hFFFFFFFF_00000000, 8'd2, 32'h1008, 8'd0};
    vecs[5] = '{64'h00000001_80000000, 8'd0, 32'h1000, 8'd0};
    vecs[6] = '{64'h13579BDF_2468ACE0, 8'd0, 32'h1000, 8'd0};
    vecs[7] = '{64'h55AA55AA_AA55AA55, 8'd8, 32'h1000, 8'd1};

    rst = 1'b1;
    report_i = '0;
    report_valid_i = 1'b0;
    enable_i = 1'b1;
    base_addr_i = 32'h1000;
    depth_i = 8'd3;
    m_ptr = 8'd0;
    repeat (3) @(negedge clk);
    chk_all_reset("rst");
    rst = 1'b0;

    // Ring pointer / address vectors
    foreach (vecs[i]) begin
      depth_i = vecs[i].depth;
      push_rpt(vecs[i].exp_addr, vecs[i].rpt);
      send_report(vecs[i].rpt);
      wait_irq($sformatf("vec%0d", i));
      @(negedge clk);
      chk($sformatf("vec%0d_ptr", i), wr_ptr_o, vecs[i].exp_ptr);
      chk($sformatf("vec%0d_irq_pulse", i), irq_o, 1'b0);
      m_ptr = vecs[i].exp_ptr;
    end
    depth_i = 8'd8;

    // AW accepted well before W, then the reverse
    aw_delay = 0; w_delay = 3;
    expect_next(64'hAAAA0001_BBBB0002);
    send_report(64'hAAAA0001_BBBB0002);
    wait_irq("awfirst");
    @(negedge clk);
    chk("awfirst_ptr", wr_ptr_o, m_ptr);
    aw_delay = 3; w_delay = 0;
    expect_next(64'hCCCC0003_DDDD0004);
    send_report(64'hCCCC0003_DDDD0004);
    wait_irq("wfirst");
    @(negedge clk);
    chk("wfirst_ptr", wr_ptr_o, m_ptr);
    aw_delay = 0; w_delay = 0;

    // Edge with enable low is ignored without overflow
    wr_base = wr_cnt;
    enable_i = 1'b0;
    send_report(64'h0BAD0BAD_0BAD0BAD);
    repeat (12) @(negedge clk);
    chk("dis_writes", wr_cnt - wr_base, 0);
    chk("dis_ovf", overflow_o, 1'b0);
    enable_i = 1'b1;

    // Second edge lands in ADV and is held; third overflows
    wr_base = wr_cnt;
    expect_next(64'h11110000_22220000);
    send_report(64'h11110000_22220000);
    wait_irq("ovf_a");
    expect_next(64'h33330000_44440000);
    report_i = 64'h33330000_44440000;
    report_valid_i = 1'b1;
    @(negedge clk);
    report_valid_i = 1'b0;
    @(negedge clk);
    chk("ovf_pre", overflow_o, 1'b0);
    send_report(64'h55550000_66660000);
    chk("ovf_set", overflow_o, 1'b1);
    wait_irq("ovf_b");
    repeat (20) @(negedge clk);
    chk("ovf_writes", wr_cnt - wr_base, 4);
    chk("ovf_sticky", overflow_o, 1'b1);
    chk("ovf_ptr", wr_ptr_o, m_ptr);

    // SLVERR on the low word: sticky error, sequence completes
    chk("err_pre", err_o, 1'b0);
    err_lo_once = 1'b1;
    expect_next(64'h77778888_9999AAAA);
    send_report(64'h77778888_9999AAAA);
    wait_irq("err");
    @(negedge clk);
    chk("err_set", err_o, 1'b1);
    chk("err_ptr", wr_ptr_o, m_ptr);
    repeat (5) @(negedge clk);
    chk("err_sticky", err_o, 1'b1);

    // Reset while waiting on the low-word response
    b_hold = 1'b1;
    expect_next(64'hFEEDFACE_12345678);
    send_report(64'hFEEDFACE_12345678);
    wait_bready("abort");
    chk("abort_ptr_nz", (wr_ptr_o != 8'd0), 1'b1);
    rst = 1'b1;
    #1;
    chk_all_reset("abort");
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    b_hold = 1'b0;
    m_ptr = 8'd0;
    expect_next(64'h0F1E2D3C_4B5A6978);
    send_report(64'h0F1E2D3C_4B5A6978);
    wait_irq("post_rst");
    @(negedge clk);
    chk("post_rst_ptr", wr_ptr_o, 8'd1);
    chk("post_rst_err", err_o, 1'b0);

    repeat (5) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
